// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the multicycle processor control path.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } proc_ctrl_state_t;

  typedef logic [3:0] proc_opcode_t;

  localparam proc_opcode_t OP_ALU_R = 4'h0;
  localparam proc_opcode_t OP_ALU_I = 4'h1;
  localparam proc_opcode_t OP_LOAD  = 4'h2;
  localparam proc_opcode_t OP_STORE = 4'h3;
  localparam proc_opcode_t OP_BEQ   = 4'h4;
  localparam proc_opcode_t OP_JMP   = 4'h5;
  localparam proc_opcode_t OP_HALT  = 4'hF;
  // Opcode register value out of reset; encodes as a harmless register-register op.
  localparam proc_opcode_t OP_NOP   = 4'h0;

  localparam logic [1:0] PC_SEL_PC4    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

  // HALT counts as legal: it halts cleanly without flagging an illegal instruction.
  function automatic logic opcode_is_legal(input proc_opcode_t op);
    return (op <= OP_JMP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational decode of the latched opcode into datapath mux controls.
module proc_ctrl_decode
  import proc_ctrl_pkg::*;
(
  input  logic [3:0] op,
  input  logic [2:0] state,
  output logic       alu_src_imm,
  output logic       dmem_we,
  output logic       wb_sel,
  output logic       is_legal
);

  // Mux controls are qualified by the state in which the datapath consumes them.
  always_comb begin
    alu_src_imm = 1'b0;
    dmem_we     = 1'b0;
    wb_sel      = 1'b0;
    is_legal    = opcode_is_legal(op);
    if (state == EXECUTE) begin
      alu_src_imm = (op == OP_ALU_I) || (op == OP_LOAD) || (op == OP_STORE);
    end
    if (state == MEMORY) begin
      dmem_we = (op == OP_STORE);
    end
    if (state == WRITEBACK) begin
      wb_sel = (op == OP_LOAD);
    end
  end

endmodule

// File: rtl/proc_multicycle_ctrl.sv
// Main control FSM of the multicycle processor with retired-instruction counter.
module proc_multicycle_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int OPC_MSB = 31
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src_imm,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  proc_ctrl_state_t state_q, state_d;
  proc_opcode_t     op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             dec_is_legal;
  logic             unused_instr_bits;

  // Only the opcode field is consumed here; the rest of the word belongs to the datapath.
  assign unused_instr_bits = ^instr;

  proc_ctrl_decode u_decode (
    .op          (op_q),
    .state       (state_q),
    .alu_src_imm (alu_src_imm),
    .dmem_we     (dmem_we),
    .wb_sel      (wb_sel),
    .is_legal    (dec_is_legal)
  );

  // Next-state, handshake and strobe generation; strobes are held low while reset is asserted.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PC4;
    rf_we     = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = PC_SEL_PC4;
          op_d    = instr[OPC_MSB -: 4];
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (op_q == OP_HALT) begin
          state_d = HALT;
        end else if (!dec_is_legal) begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        case (op_q)
          OP_ALU_R, OP_ALU_I: state_d = WRITEBACK;
          OP_LOAD, OP_STORE:  state_d = MEMORY;
          OP_BEQ: begin
            if (alu_zero) begin
              pc_we  = 1'b1;
              pc_sel = PC_SEL_BRANCH;
            end
            state_d = FETCH;
            retire  = 1'b1;
          end
          OP_JMP: begin
            pc_we   = 1'b1;
            pc_sel  = PC_SEL_JUMP;
            state_d = FETCH;
            retire  = 1'b1;
          end
          default: state_d = HALT;
        endcase
      end
      MEMORY: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          if (op_q == OP_LOAD) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        rf_we   = 1'b1;
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = FETCH;
    endcase

    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = PC_SEL_PC4;
      rf_we    = 1'b0;
    end

    instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;
  end

  // State, latched opcode, sticky illegal flag and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      op_q      <= OP_NOP;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == HALT);
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_proc_multicycle_ctrl.sv
// Directed testbench for the multicycle control FSM.
module tb_proc_multicycle_ctrl;
  import proc_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_ack;
  logic [31:0] instr;
  logic        alu_zero;
  logic        dmem_ack;

  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_imm, rf_we, wb_sel;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        halted, illegal;
  logic [31:0] instret;

  logic        s_imem_req, s_dmem_req, s_dmem_we, s_ir_we, s_pc_we, s_alu_src_imm, s_rf_we, s_wb_sel;
  logic [1:0]  s_pc_sel;
  logic [2:0]  s_state;
  logic        s_halted, s_illegal;
  logic [2:0]  s_instret;

  int checkCount = 0;
  int passCount  = 0;
  int expInstret = 0;
  int reqCycles  = 0;

  proc_multicycle_ctrl #(.CNT_W(32), .OPC_MSB(31)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .alu_zero(alu_zero), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_imm(alu_src_imm),
    .rf_we(rf_we), .wb_sel(wb_sel), .state(state), .halted(halted), .illegal(illegal),
    .instret(instret)
  );

  // Narrow-counter instance sharing all stimulus, so counter wrap is reached in a few retires.
  proc_multicycle_ctrl #(.CNT_W(3), .OPC_MSB(31)) dut_small (
    .clk(clk), .rst(rst), .imem_req(s_imem_req), .imem_ack(imem_ack), .instr(instr),
    .alu_zero(alu_zero), .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .dmem_ack(dmem_ack),
    .ir_we(s_ir_we), .pc_we(s_pc_we), .pc_sel(s_pc_sel), .alu_src_imm(s_alu_src_imm),
    .rf_we(s_rf_we), .wb_sel(s_wb_sel), .state(s_state), .halted(s_halted),
    .illegal(s_illegal), .instret(s_instret)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Advance one cycle, then drive this cycle's inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic ia, input logic da, input logic [31:0] ins, input logic z);
    @(posedge clk);
    #1;
    imem_ack = ia;
    dmem_ack = da;
    instr    = ins;
    alu_zero = z;
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; instr = 32'h0; alu_zero = 1'b0;
    @(posedge clk); #1; @(posedge clk); #2;
    $display("[TB] reset");
    checkOutput("rst_state",    32'(state),    32'(FETCH));
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_instret",  instret,       32'd0);
    checkOutput("rst_halted",   32'(halted),   32'd0);
    checkOutput("rst_illegal",  32'(illegal),  32'd0);
    checkOutput("rst_pc_sel",   32'(pc_sel),   32'd0);
    rst = 1'b0;

    $display("[TB] ALU_R with immediate fetch ack");
    applyStimulus(1'b1, 1'b0, 32'h0000_0123, 1'b0);
    checkOutput("alu_c0_state",  32'(state),    32'(FETCH));
    checkOutput("alu_c0_ireq",   32'(imem_req), 32'd1);
    checkOutput("alu_c0_ir_we",  32'(ir_we),    32'd1);
    checkOutput("alu_c0_pc_we",  32'(pc_we),    32'd1);
    checkOutput("alu_c0_pc_sel", 32'(pc_sel),   32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("alu_c1_state",  32'(state),    32'(DECODE));
    checkOutput("alu_c1_ir_we",  32'(ir_we),    32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("alu_c2_state",  32'(state),       32'(EXECUTE));
    checkOutput("alu_c2_imm",    32'(alu_src_imm), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("alu_c3_state",  32'(state),  32'(WRITEBACK));
    checkOutput("alu_c3_rf_we",  32'(rf_we),  32'd1);
    checkOutput("alu_c3_wb_sel", 32'(wb_sel), 32'd0);
    checkOutput("alu_c3_instret", instret,    32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    expInstret = 1;
    checkOutput("alu_c4_state",  32'(state), 32'(FETCH));
    checkOutput("alu_c4_instret", instret,   32'(expInstret));

    $display("[TB] LOAD with fetch and memory wait states");
    applyStimulus(1'b0, 1'b0, 32'h2000_0000, 1'b0);
    checkOutput("ld_wait0_ireq",  32'(imem_req), 32'd1);
    checkOutput("ld_wait0_ir_we", 32'(ir_we),    32'd0);
    applyStimulus(1'b0, 1'b0, 32'h2000_0000, 1'b0);
    checkOutput("ld_wait1_ireq",  32'(imem_req), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h2000_0000, 1'b0);
    checkOutput("ld_ack_ir_we",   32'(ir_we),    32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ld_dec_state",   32'(state),    32'(DECODE));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ld_ex_imm",      32'(alu_src_imm), 32'd1);
    reqCycles = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, (i == 3), 32'h0, 1'b0);
      if (dmem_req) reqCycles++;
      checkOutput("ld_mem_dmem_we", 32'(dmem_we), 32'd0);
    end
    checkOutput("ld_req_cycles", 32'(reqCycles), 32'd4);
    checkOutput("ld_mem_state",  32'(state),     32'(MEMORY));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ld_wb_rf_we",   32'(rf_we),  32'd1);
    checkOutput("ld_wb_sel",     32'(wb_sel), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    expInstret = 2;
    checkOutput("ld_instret", instret, 32'(expInstret));

    $display("[TB] STORE plus stray data ack in FETCH");
    applyStimulus(1'b1, 1'b0, 32'h3000_0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("st_ex_imm",   32'(alu_src_imm), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("st_mem_req",  32'(dmem_req), 32'd1);
    checkOutput("st_mem_we0",  32'(dmem_we),  32'd1);
    checkOutput("st_rf_we0",   32'(rf_we),    32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    checkOutput("st_mem_we1",  32'(dmem_we),  32'd1);
    checkOutput("st_rf_we1",   32'(rf_we),    32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    expInstret = 3;
    checkOutput("st_back_state", 32'(state),    32'(FETCH));
    checkOutput("st_instret",    instret,       32'(expInstret));
    checkOutput("st_stray_dreq", 32'(dmem_req), 32'd0);
    checkOutput("st_stray_irwe", 32'(ir_we),    32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("stray_dack_state", 32'(state), 32'(FETCH));

    $display("[TB] BEQ taken and not taken");
    for (int t = 0; t < 2; t++) begin
      applyStimulus(1'b1, 1'b0, 32'h4000_0000, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, (t == 0));
      checkOutput("beq_ex_state", 32'(state), 32'(EXECUTE));
      checkOutput("beq_pc_we",    32'(pc_we),  (t == 0) ? 32'd1 : 32'd0);
      if (t == 0) checkOutput("beq_pc_sel", 32'(pc_sel), 32'(PC_SEL_BRANCH));
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      expInstret++;
      checkOutput("beq_back_state", 32'(state), 32'(FETCH));
      checkOutput("beq_instret",    instret,    32'(expInstret));
    end

    $display("[TB] JMP sequence, narrow counter wraps");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h5000_0000, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("jmp_pc_we",  32'(pc_we),  32'd1);
      checkOutput("jmp_pc_sel", 32'(pc_sel), 32'(PC_SEL_JUMP));
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      expInstret++;
      checkOutput("jmp_instret",       instret,        32'(expInstret));
      checkOutput("jmp_small_instret", 32'(s_instret), 32'(expInstret % 8));
    end

    $display("[TB] reset during data access");
    applyStimulus(1'b1, 1'b0, 32'h2000_0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("mrst_pre_dreq", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    expInstret = 0;
    checkOutput("mrst_state",   32'(state),    32'(FETCH));
    checkOutput("mrst_dreq",    32'(dmem_req), 32'd0);
    checkOutput("mrst_ireq",    32'(imem_req), 32'd0);
    checkOutput("mrst_instret", instret,       32'(expInstret));
    rst = 1'b0;

    $display("[TB] ALU_I");
    applyStimulus(1'b1, 1'b0, 32'h1000_0042, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("alui_imm", 32'(alu_src_imm), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("alui_rf_we", 32'(rf_we), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    expInstret = 1;
    checkOutput("alui_instret", instret, 32'(expInstret));

    $display("[TB] illegal opcode");
    applyStimulus(1'b1, 1'b0, 32'h7000_0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ill_dec_halted", 32'(halted), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ill_state",   32'(state),   32'(HALT));
    checkOutput("ill_halted",  32'(halted),  32'd1);
    checkOutput("ill_illegal", 32'(illegal), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'hF000_0000, 1'b1);
    checkOutput("halt_stray_ireq",  32'(imem_req), 32'd0);
    checkOutput("halt_stray_dreq",  32'(dmem_req), 32'd0);
    checkOutput("halt_stray_ir_we", 32'(ir_we),    32'd0);
    checkOutput("halt_stray_pc_we", 32'(pc_we),    32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("halt_stay_state", 32'(state), 32'(HALT));
    checkOutput("halt_instret",    instret,    32'(expInstret));
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("halt_rst_state",   32'(state),   32'(FETCH));
    checkOutput("halt_rst_illegal", 32'(illegal), 32'd0);
    checkOutput("halt_rst_halted",  32'(halted),  32'd0);

    $display("[TB] HALT opcode");
    applyStimulus(1'b1, 1'b0, 32'hF000_0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("hop_state",   32'(state),   32'(HALT));
    checkOutput("hop_halted",  32'(halted),  32'd1);
    checkOutput("hop_illegal", 32'(illegal), 32'd0);
    checkOutput("hop_instret", instret,      32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
